// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: iterative SHA-256 compression controller.
// Performs one round per accepted W[t] word, then adds the working
// variables back into the chaining value to form the digest.
// Optional feature: define SHA256_CTRL_ABORT_EN to add an `abort` input
// that drops an in-flight block and returns to IDLE.
module sha256_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_data,
  input  logic         w_valid,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [5:0]   round
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  logic [1:0]   r_state;
  logic [5:0]   r_round;
  logic [255:0] r_chain;
  logic [255:0] r_digest;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_hv;

  logic         w_abort;
  logic         w_xfer;
  logic [31:0]  w_t1;
  logic [31:0]  w_t2;
  logic [255:0] w_sum;

`ifdef SHA256_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_ready = (r_state == S_ROUND);
  assign w_xfer  = w_ready && w_valid;

  // One round of the compression function on the current working variables.
  assign w_t1 = r_hv + big_sigma1(r_e) + ((r_e & r_f) ^ (~r_e & r_g))
              + K_ROM[r_round] + w_data;
  assign w_t2 = big_sigma0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));

  assign w_sum = {r_chain[255:224] + r_a,  r_chain[223:192] + r_b,
                  r_chain[191:160] + r_c,  r_chain[159:128] + r_d,
                  r_chain[127:96]  + r_e,  r_chain[95:64]   + r_f,
                  r_chain[63:32]   + r_g,  r_chain[31:0]    + r_hv};

  // Control FSM, round counter, working variables and digest register.
  // NOTE: every state register uses <= so all updates see pre-edge values;
  // the a..h shift relies on that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_round  <= 6'd0;
      r_chain  <= '0;
      r_digest <= '0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_hv} <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_round <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chain <= h_in;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_hv} <= h_in;
            r_round <= 6'd0;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (w_xfer) begin
            r_a     <= w_t1 + w_t2;
            r_b     <= r_a;
            r_c     <= r_b;
            r_d     <= r_c;
            r_e     <= r_d + w_t1;
            r_f     <= r_e;
            r_g     <= r_f;
            r_hv    <= r_g;
            r_round <= r_round + 6'd1;
            if (r_round == 6'd63) r_state <= S_FINAL;
          end
        end
        S_FINAL: begin
          r_digest <= w_sum;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign digest = r_digest;
  assign round  = r_round;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: directed known-answer bench for sha256_round_ctrl.
// Table of single-block vectors plus hand-written sequences for reset,
// back-to-back chaining and (with SHA256_CTRL_ABORT_EN) abort.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] h_in = '0;
  logic [31:0]  w_data = '0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] digest;
  logic [5:0]   round;
`ifdef SHA256_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  sha256_round_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .h_in    (h_in),
    .w_data  (w_data),
    .w_valid (w_valid),
`ifdef SHA256_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .w_ready (w_ready),
    .busy    (busy),
    .done    (done),
    .digest  (digest),
    .round   (round)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  localparam int M_NORMAL = 0;
  localparam int M_STALL  = 1;
  localparam int M_IGNORE = 2;
  localparam int M_RESET  = 3;
  localparam int M_ABORT  = 4;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic [255:0] h;
    int           mode;
    logic [255:0] exp_digest;
    int           exp_cycle;
    int           exp_dones;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int done_count = 0;
  logic [31:0] w_sched [64];

  always @(negedge clk) if (done) done_count++;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule expansion: the bench's golden source of W[16..63].
  function automatic void load_sched(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) w_sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      logic [31:0] s0, s1;
      s0 = ror(w_sched[i-15], 7) ^ ror(w_sched[i-15], 18) ^ (w_sched[i-15] >> 3);
      s1 = ror(w_sched[i-2], 17) ^ ror(w_sched[i-2], 19) ^ (w_sched[i-2] >> 10);
      w_sched[i] = w_sched[i-16] + s0 + w_sched[i-7] + s1;
    end
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},    {255'h0, busy},    256'h0);
    check({tag, " done"},    {255'h0, done},    256'h0);
    check({tag, " w_ready"}, {255'h0, w_ready}, 256'h0);
    check({tag, " round"},   {250'h0, round},   256'h0);
    check({tag, " digest"},  digest,            256'h0);
  endtask

  // Runs one block from the current slot (#1 after an edge, FSM idle).
  // Returns in the first IDLE slot after done, or right after reset/abort.
  task automatic run_block(input logic [255:0] h, input int mode,
                           output int done_cyc);
    int t, cyc, stall_left;
    bit s10, s63, xfer;
    done_cyc = -1;
    h_in = h; start = 1'b1; w_valid = 1'b1; w_data = 32'hdeadbeef;
    @(posedge clk); #1;
    start = 1'b0; h_in = '1;
    t = 0; cyc = 1; stall_left = 0; s10 = 0; s63 = 0;
    while (cyc < 200) begin
      if (mode == M_STALL && stall_left == 0 && t == 10 && !s10) begin
        stall_left = 5; s10 = 1;
      end
      if (mode == M_STALL && stall_left == 0 && t == 63 && !s63) begin
        stall_left = 3; s63 = 1;
      end
      w_valid = (stall_left == 0);
      w_data  = (t < 64) ? w_sched[t] : 32'hdeadbeef;
      start   = (mode == M_IGNORE && t == 20);
      if (t < 64 && (stall_left > 0 || t == 0 || t == 63))
        check($sformatf("round at t=%0d", t), {250'h0, round}, 256'(t));
      if (mode == M_RESET && t == 30) begin
        #2 rst = 1'b0;
        #1 check_zero_outputs("async reset");
        w_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        return;
      end
`ifdef SHA256_CTRL_ABORT_EN
      if (mode == M_ABORT && t == 40) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; w_valid = 1'b0;
        check("abort busy",    {255'h0, busy},    256'h0);
        check("abort w_ready", {255'h0, w_ready}, 256'h0);
        check("abort done",    {255'h0, done},    256'h0);
        check("abort digest",  digest,            TWO_DIG);
        return;
      end
`endif
      if (done) begin
        done_cyc = cyc;
        start = (mode == M_IGNORE);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after done", {255'h0, busy}, 256'h0);
        return;
      end
      xfer = w_valid && w_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer) t++;
      if (stall_left > 0) stall_left--;
    end
    check("done timeout", 256'(cyc), 256'd0);
  endtask

  vec_t vecs [4];

  initial begin
    int dc, d0;
    logic [255:0] h2;

    vecs[0] = '{"abc",         ABC_BLK,   IV, M_NORMAL, ABC_DIG,   66, 1};
    vecs[1] = '{"abc stalled", ABC_BLK,   IV, M_STALL,  ABC_DIG,   74, 1};
    vecs[2] = '{"abc ignored", ABC_BLK,   IV, M_IGNORE, ABC_DIG,   66, 1};
    vecs[3] = '{"empty",       EMPTY_BLK, IV, M_NORMAL, EMPTY_DIG, 66, 1};

    #12 check_zero_outputs("reset");
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      load_sched(vecs[i].blk);
      d0 = done_count;
      run_block(vecs[i].h, vecs[i].mode, dc);
      check({vecs[i].name, " done cycle"}, 256'(dc), 256'(vecs[i].exp_cycle));
      check({vecs[i].name, " digest"}, digest, vecs[i].exp_digest);
      check({vecs[i].name, " done pulses"}, 256'(done_count - d0),
            256'(vecs[i].exp_dones));
      repeat (2) @(posedge clk);
      #1;
    end

    // Mid-block asynchronous reset, then an immediate fresh block.
    load_sched(ABC_BLK);
    d0 = done_count;
    run_block(IV, M_RESET, dc);
    check("reset block no done", 256'(done_count - d0), 256'd0);
    run_block(IV, M_NORMAL, dc);
    check("post-reset done cycle", 256'(dc), 256'd66);
    check("post-reset digest", digest, ABC_DIG);
    check("post-reset done pulses", 256'(done_count - d0), 256'd1);

    // Back-to-back two-block message, second block chained from the first.
    d0 = done_count;
    load_sched(TWO_BLK1);
    run_block(IV, M_NORMAL, dc);
    check("two-block first done cycle", 256'(dc), 256'd66);
    h2 = digest;
    load_sched(TWO_BLK2);
    run_block(h2, M_NORMAL, dc);
    check("two-block second done cycle", 256'(dc), 256'd66);
    check("two-block digest", digest, TWO_DIG);
    check("two-block done pulses", 256'(done_count - d0), 256'd2);

`ifdef SHA256_CTRL_ABORT_EN
    d0 = done_count;
    load_sched(ABC_BLK);
    run_block(IV, M_ABORT, dc);
    repeat (80) @(posedge clk);
    #1;
    check("abort no done", 256'(done_count - d0), 256'd0);
    check("abort digest held", digest, TWO_DIG);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` is the clock and `rst` is the reset.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 Port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `start`, input, 1 bit: begin one compression block; sampled only in IDLE.
REQ-005 Port `h_in`, input, 256 bits: chaining state H0..H7, with H0 in [255:224]; captured on an accepted `start`.
REQ-006 Port `w_data`, input, 32 bits: message-schedule word W[t] for the current round.
REQ-007 Port `w_valid`, input, 1 bit: `w_data` is valid.
REQ-008 Port `w_ready`, output, 1 bit: the controller accepts W[t] this cycle.
REQ-009 Port `busy`, output, 1 bit: high from an accepted `start` until `done`.
REQ-010 Port `done`, output, 1 bit: one-cycle pulse when `digest` becomes valid.
REQ-011 Port `digest`, output, 256 bits: result H'0..H'7, with H'0 in [255:224]; held until the next `done`.
REQ-012 Port `round`, output, 6 bits: index t of the next W word expected.

Function
REQ-013 The FSM SHALL have states IDLE, ROUND, FINAL and DONE; all other encodings SHALL go to IDLE.
REQ-014 IDLE: `start`=1 SHALL capture `h_in` into H and into working variables a..h, clear `round`, and go to ROUND; otherwise the FSM stays in IDLE.
REQ-015 ROUND: `w_ready`=1; a transfer occurs on `w_valid` & `w_ready`.
REQ-016 On each transfer the block SHALL perform exactly one SHA-256 round:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Ch(e,f,g): bitwise select, f where e=1 and g where e=0.
  - All sums are modulo 2^32, with carries discarded.
REQ-017 K[0..63] SHALL be the FIPS 180-4 constants, held in an internal ROM indexed by `round`.
REQ-018 With no transfer (`w_valid`=0) in ROUND, a..h and `round` SHALL hold.
REQ-019 On the transfer at t=63 the FSM SHALL go to FINAL; `round` SHALL wrap to 0.
REQ-020 FINAL (1 cycle): `digest` SHALL load Hi+var_i mod 2^32 for each word, and the FSM SHALL go to DONE.
REQ-021 DONE (1 cycle): `done`=1, `busy` stays 1, then the FSM SHALL go to IDLE.
REQ-022 Latency SHALL be 64 transfers plus 2 cycles from the last transfer to the `done` pulse, i.e. a minimum of 66 cycles after `start` is accepted.
REQ-023 `start` outside IDLE SHALL be ignored, with no restart and no queuing.
REQ-024 `w_ready` SHALL be 0 in IDLE, FINAL and DONE; `w_valid` in those states SHALL be ignored.
REQ-025 `start` in the cycle after DONE SHALL be accepted, giving back-to-back blocks.

Reset
REQ-026 `rst`=0 SHALL immediately apply the following:
  - FSM goes to IDLE.
  - `busy`, `done` and `w_ready` go to 0.
  - `round` goes to 0.
  - `digest`, H and a..h go to 0.
REQ-027 A reset during ROUND or FINAL SHALL abandon the block; no `done` SHALL follow.
REQ-028 After `rst` deasserts, the block SHALL accept `start` on the first clock edge.

Configuration
REQ-029 Macro `SHA256_CTRL_ABORT_EN` SHALL control an abort feature.
  - Defined: adds 1-bit input `abort`. `abort`=1 in any non-IDLE state SHALL return to IDLE at the next edge, with `busy`=0, no `done`, and `digest` unchanged.
  - Not defined: the port is absent, and blocks always run to completion.

Verification
REQ-030 Known-answer test: H = SHA-256 IV; W from padded "abc" (W0=61626380, W1..W14=0, W15=00000018, W16..63 from a golden model), `w_valid` held 1.
  - `done` at cycle 66.
  - `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-031 Stalls: same stimulus, `w_valid` dropped for 5 cycles at t=10 and for 3 cycles at t=63.
  - `round` holds during each stall.
  - Identical `digest`; `done` 8 cycles later than in REQ-030.
REQ-032 Ignored start: `start` pulsed at t=20 and again during DONE.
  - No restart; the REQ-030 digest is produced.
  - `busy` falls after the single `done`.
REQ-033 Mid-block reset: `rst`=0 asynchronously at t=30 (between edges).
  - All outputs 0 immediately.
  - No `done`; a following "abc" block yields the REQ-030 digest.
REQ-034 Back-to-back: `start` in the cycle after `done`, with a second block chained from the first digest.
  - Second `digest` matches the golden two-block result.
  - Exactly two `done` pulses.
REQ-035 Abort (`SHA256_CTRL_ABORT_EN` defined): `abort` at t=40.
  - IDLE next cycle, `busy`=0, no `done`.
  - `digest` keeps its prior value.
